// File: rtl/div_seq.sv
// div_seq: iterative signed divider, 2W-bit dividend by W-bit divisor.
// Restoring division on magnitudes, one quotient bit per enabled clock,
// followed by a single fix-up cycle that applies signs and saturation.
module div_seq #(
   parameter int W = 16
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             ce,
   input  logic             start,
   input  logic [2*W-1:0]   A,
   input  logic [W-1:0]     B,
   output logic [W-1:0]     Q,
   output logic [W-1:0]     R,
   output logic             busy,
   output logic             done,
   output logic             ovf,
   output logic             dbz
);

   localparam int CW = $clog2(2 * W);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;

   localparam logic [W-1:0] Q_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] Q_MIN = {1'b1, {(W-1){1'b0}}};

   logic [1:0]     state_q, state_d;
   logic [2*W-1:0] dvd_q, dvd_d;     // dividend magnitude, shifts in quotient bits
   logic [W-1:0]   rem_q, rem_d;     // partial remainder magnitude
   logic [W-1:0]   bmag_q, bmag_d;   // divisor magnitude
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           sa_q, sa_d;
   logic           sb_q, sb_d;
   logic           dz_q, dz_d;
   logic [W-1:0]   quot_q, quot_d;
   logic [W-1:0]   rmd_q, rmd_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           ovf_q, ovf_d;
   logic           dbz_q, dbz_d;

   logic [W:0]     shifted;
   logic [W:0]     diff;
   logic           qbit;
   logic           q_neg;
   logic [W:0]     sat_res;

   // Magnitude of the dividend; the most negative value maps to 2^(2W-1).
   function automatic logic [2*W-1:0] abs_dvd(input logic signed [2*W-1:0] a);
      return (a < 0) ? -a : a;
   endfunction

   // Magnitude of the divisor; the most negative value maps to 2^(W-1).
   function automatic logic [W-1:0] abs_dvs(input logic signed [W-1:0] b);
      return (b < 0) ? -b : b;
   endfunction

   // Signs and saturates a quotient magnitude; MSB of the result is the overflow flag.
   function automatic logic [W:0] sat_quot(input logic [2*W-1:0] mag, input logic neg);
      logic [2*W-1:0]      lim;
      logic signed [W-1:0] q_s;
      lim = (2*W)'(1) << (W - 1);
      if (!neg) begin
         lim = lim - (2*W)'(1);
      end
      if (mag > lim) begin
         return {1'b1, neg ? Q_MIN : Q_MAX};
      end
      q_s = neg ? -mag[W-1:0] : mag[W-1:0];
      return {1'b0, q_s};
   endfunction

   // Remainder carries the dividend sign; a zero magnitude stays zero.
   function automatic logic [W-1:0] sign_rem(input logic [W-1:0] mag, input logic neg);
      logic signed [W-1:0] r_s;
      r_s = neg ? -mag : mag;
      return r_s;
   endfunction

   // Next-state logic: operand capture, one restoring step, sign fix-up.
   always_comb begin
      state_d = state_q;
      dvd_d   = dvd_q;
      rem_d   = rem_q;
      bmag_d  = bmag_q;
      cnt_d   = cnt_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      dz_d    = dz_q;
      quot_d  = quot_q;
      rmd_d   = rmd_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      ovf_d   = ovf_q;
      dbz_d   = dbz_q;
      shifted = {rem_q, dvd_q[2*W-1]};
      diff    = shifted - {1'b0, bmag_q};
      qbit    = 1'b0;
      q_neg   = 1'b0;
      sat_res = '0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               sa_d   = A[2*W-1];
               sb_d   = B[W-1];
               bmag_d = abs_dvs(B);
               rem_d  = '0;
               cnt_d  = CW'(2 * W - 1);
               busy_d = 1'b1;
               if (B == '0) begin
                  // Raw dividend kept so its low half can be returned as R.
                  dz_d    = 1'b1;
                  dvd_d   = A;
                  state_d = ST_FIX;
               end else begin
                  dz_d    = 1'b0;
                  dvd_d   = abs_dvd(A);
                  state_d = ST_CALC;
               end
            end
         end
         ST_CALC: begin
            if (shifted >= {1'b0, bmag_q}) begin
               qbit  = 1'b1;
               rem_d = diff[W-1:0];
            end else begin
               rem_d = shifted[W-1:0];
            end
            dvd_d = {dvd_q[2*W-2:0], qbit};
            if (cnt_q == '0) begin
               state_d = ST_FIX;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_FIX: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
            if (dz_q) begin
               dbz_d  = 1'b1;
               ovf_d  = 1'b0;
               quot_d = dvd_q[2*W-1] ? Q_MIN : Q_MAX;
               rmd_d  = dvd_q[W-1:0];
            end else begin
               q_neg   = (sa_q ^ sb_q) && (dvd_q != '0);
               sat_res = sat_quot(dvd_q, q_neg);
               dbz_d   = 1'b0;
               ovf_d   = sat_res[W];
               quot_d  = sat_res[W-1:0];
               rmd_d   = sign_rem(rem_q, sa_q);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers; ce=0 freezes everything, reset aborts any operation.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q <= ST_IDLE;
         dvd_q   <= '0;
         rem_q   <= '0;
         bmag_q  <= '0;
         cnt_q   <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         dz_q    <= 1'b0;
         quot_q  <= '0;
         rmd_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         dbz_q   <= 1'b0;
      end else if (ce) begin
         state_q <= state_d;
         dvd_q   <= dvd_d;
         rem_q   <= rem_d;
         bmag_q  <= bmag_d;
         cnt_q   <= cnt_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         dz_q    <= dz_d;
         quot_q  <= quot_d;
         rmd_q   <= rmd_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
         dbz_q   <= dbz_d;
      end
   end

   assign Q    = quot_q;
   assign R    = rmd_q;
   assign busy = busy_q;
   assign done = done_q;
   assign ovf  = ovf_q;
   assign dbz  = dbz_q;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: scoreboard bench for div_seq with a cycle-level handshake model
// and a plain-arithmetic reference for quotient, remainder and flags.
module tb_div_seq;

   localparam int W = 16;

   logic           clk = 1'b0;
   logic           arst_n;
   logic           ce;
   logic           start;
   logic [2*W-1:0] A;
   logic [W-1:0]   B;
   logic [W-1:0]   Q;
   logic [W-1:0]   R;
   logic           busy;
   logic           done;
   logic           ovf;
   logic           dbz;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         ovf;
      logic         dbz;
   } res_t;

   res_t sb_fifo[$];
   res_t held;
   int   n_checks = 0;
   int   n_errors = 0;
   int   m_rem    = 0;     // enabled edges left until the expected done
   bit   m_done   = 1'b0;

   bit             s_ce, s_start, s_rst;
   logic [2*W-1:0] s_a;
   logic [W-1:0]   s_b;

   div_seq #(.W(W)) dut (
      .clk    (clk),
      .arst_n (arst_n),
      .ce     (ce),
      .start  (start),
      .A      (A),
      .B      (B),
      .Q      (Q),
      .R      (R),
      .busy   (busy),
      .done   (done),
      .ovf    (ovf),
      .dbz    (dbz)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Truncating signed division with saturation, straight from the arithmetic rules.
   function automatic res_t ref_div(input logic [2*W-1:0] a, input logic [W-1:0] b);
      res_t   e;
      longint la, lb, lq, lr, qmax, qmin;
      la   = longint'($signed(a));
      lb   = longint'($signed(b));
      qmax = (longint'(1) <<< (W - 1)) - 1;
      qmin = -(longint'(1) <<< (W - 1));
      if (lb == 0) begin
         e.dbz = 1'b1;
         e.ovf = 1'b0;
         e.q   = (la >= 0) ? qmax[W-1:0] : qmin[W-1:0];
         e.r   = a[W-1:0];
      end else begin
         lq    = la / lb;
         lr    = la % lb;
         e.dbz = 1'b0;
         e.ovf = 1'b0;
         if (lq > qmax) begin
            e.ovf = 1'b1;
            e.q   = qmax[W-1:0];
         end else if (lq < qmin) begin
            e.ovf = 1'b1;
            e.q   = qmin[W-1:0];
         end else begin
            e.q = lq[W-1:0];
         end
         e.r = lr[W-1:0];
      end
      return e;
   endfunction

   // Handshake model plus monitor: predicts busy/done, pushes on accept, pops on DUT done.
   always @(posedge clk) begin
      s_ce    = ce;
      s_start = start;
      s_rst   = !arst_n;
      s_a     = A;
      s_b     = B;
      if (!s_rst) begin
         if (s_ce) begin
            m_done = 1'b0;
            if (m_rem > 0) begin
               m_rem--;
               if (m_rem == 0) m_done = 1'b1;
            end else if (s_start) begin
               sb_fifo.push_back(ref_div(s_a, s_b));
               m_rem = (s_b == '0) ? 1 : 2 * W + 1;
            end
         end
         #1;
         chk("busy", longint'(busy), longint'(m_rem > 0));
         chk("done", longint'(done), longint'(m_done));
         if (s_ce && done) begin
            if (sb_fifo.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               held = sb_fifo.pop_front();
            end
         end
         chk("Q", longint'(Q), longint'(held.q));
         chk("R", longint'(R), longint'(held.r));
         chk("ovf", longint'(ovf), longint'(held.ovf));
         chk("dbz", longint'(dbz), longint'(held.dbz));
      end
   end

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_Q"}, longint'(Q), 0);
      chk({tag, "_R"}, longint'(R), 0);
      chk({tag, "_busy"}, longint'(busy), 0);
      chk({tag, "_done"}, longint'(done), 0);
      chk({tag, "_ovf"}, longint'(ovf), 0);
      chk({tag, "_dbz"}, longint'(dbz), 0);
   endtask

   task automatic clear_model();
      m_rem  = 0;
      m_done = 1'b0;
      sb_fifo.delete();
      held = '{q: '0, r: '0, ovf: 1'b0, dbz: 1'b0};
   endtask

   // Waits (bounded) until the model is idle, then issues a single-cycle start.
   task automatic op(input logic [2*W-1:0] a, input logic [W-1:0] b);
      int t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (m_rem != 0 && t < 200);
      if (m_rem != 0) chk("idle_timeout", 0, 1);
      A     = a;
      B     = b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   logic [2*W-1:0] dir_a [13] = '{32'd1000, 32'hFFFF_FC18, 32'd1000, 32'hFFFF_FC18,
                                  32'h4000_0000, 32'h8000_0000, 32'hFFFF_8000,
                                  32'hFFFF_FFFB, 32'd5, 32'd0, 32'h7FFF_FFFF,
                                  32'h8000_0000, 32'd6};
   logic [W-1:0]   dir_b [13] = '{16'd7, 16'd7, 16'hFFF9, 16'hFFF9,
                                  16'd2, 16'hFFFF, 16'd1,
                                  16'd0, 16'd0, 16'd5, 16'h7FFF,
                                  16'h8000, 16'hFFF9};

   initial begin
      int t;
      int sh;
      int bsel;
      logic [2*W-1:0] ra;
      held   = '{q: '0, r: '0, ovf: 1'b0, dbz: 1'b0};
      ce     = 1'b1;
      start  = 1'b0;
      A      = '0;
      B      = '0;
      arst_n = 1'b1;
      #2 arst_n = 1'b0;
      #1 chk_reset_outputs("reset");
      repeat (2) @(negedge clk);
      arst_n = 1'b1;

      for (int i = 0; i < 13; i++) begin
         op(dir_a[i], dir_b[i]);
      end

      // Stall mid-calculation while start pulses with other operands.
      op(32'd1000, 16'd7);
      repeat (5) @(negedge clk);
      ce = 1'b0;
      for (int i = 0; i < 10; i++) begin
         A     = $urandom;
         B     = 16'($urandom);
         start = i[0];
         @(negedge clk);
      end
      ce = 1'b1;
      for (int i = 0; i < 3; i++) begin
         A     = $urandom;
         B     = 16'($urandom);
         start = 1'b1;
         @(negedge clk);
      end
      start = 1'b0;

      // Random operands, random ce and start pressure.
      for (int i = 0; i < 2500; i++) begin
         @(negedge clk);
         ce    = ($urandom % 8) != 0;
         start = ($urandom % 3) == 0;
         sh    = $urandom_range(0, 24);
         ra    = $urandom;
         A     = 32'($signed(ra) >>> sh);
         bsel  = $urandom % 10;
         if (bsel == 0)      B = '0;
         else if (bsel == 1) B = 16'd1;
         else if (bsel == 2) B = 16'hFFFF;
         else                B = 16'($urandom);
      end
      ce    = 1'b1;
      start = 1'b0;

      // Abort in the middle of a calculation, then run a fresh division.
      op(32'd12345, 16'd3);
      repeat (4) @(negedge clk);
      arst_n = 1'b0;
      clear_model();
      #1 chk_reset_outputs("abort");
      repeat (2) @(negedge clk);
      arst_n = 1'b1;
      op(32'd100, 16'd10);

      t = 0;
      while (m_rem != 0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (m_rem != 0) chk("drain_timeout", 0, 1);
      repeat (3) @(negedge clk);
      chk("scoreboard_left", longint'(sb_fifo.size()), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Iterative signed divider; the inverse operation of the MAC's pipelined multiplier.
- Takes a 2W-bit signed dividend (product width) and a W-bit signed divisor.
- Returns a W-bit quotient and W-bit remainder using a one-bit-per-cycle restoring algorithm.
- Used for normalisation/rescaling of accumulator results; start/busy/done handshake; ce stalls the whole block.

Parameters:
- W, 16, operand width. Divisor, quotient and remainder are W bits; dividend is 2*W bits.

Ports:
- clk  in  1  clock; all flops rising edge.
- arst_n  in  1  asynchronous active-low reset.
- ce  in  1  clock enable; ce=0 freezes every register, including done.
- start  in  1  request; accepted only when ce=1 and busy=0.
- A  in  2*W  signed dividend.
- B  in  W  signed divisor.
- Q  out  W  signed quotient, registered.
- R  out  W  signed remainder, registered.
- busy  out  1  high from the accepting edge until the edge that sets done.
- done  out  1  one-cycle (one ce-enabled cycle) result-valid pulse.
- ovf  out  1  quotient saturated (does not fit W-bit signed); valid with done, held.
- dbz  out  1  divide by zero; valid with done, held.

Behaviour:
- Reset: state IDLE; Q=0, R=0, busy=0, done=0, ovf=0, dbz=0; internal counter/shift registers cleared. Reset mid-operation aborts silently; no done.
- All state changes occur only on rising edges with ce=1.

State machine:
- IDLE → on start:
  - Latch |A| as a 2W-bit unsigned value (covers -2^(2W-1)), |B|, sign(A), sign(B).
  - Partial remainder = 0; counter = 2W-1; busy=1.
  - B==0 → FIX with dz flag; else → CALC.
- CALC, each edge, one restoring step:
  - Shift {rem, dividend} left 1.
  - If rem >= |B|: rem -= |B|, quotient bit = 1; else quotient bit = 0.
  - After the step where counter==0 → FIX; else counter -= 1.
  - Exactly 2W steps; the 2W-bit magnitude quotient is kept internally.
- FIX, one edge, registers all outputs, done=1, busy=0 → IDLE:
  - Sign rules (truncation toward zero):
    - Quotient is negative iff sign(A) != sign(B) and quotient magnitude != 0.
    - Remainder takes sign(A); zero remainder is 0.
  - Overflow:
    - Signed quotient outside [-2^(W-1), 2^(W-1)-1] → ovf=1.
    - Q saturates to 2^(W-1)-1 if the result sign is positive, -2^(W-1) if negative.
    - R is still the exact remainder.
  - dz: dbz=1, ovf=0, Q = 2^(W-1)-1 if A>=0 else -2^(W-1), R = A[W-1:0].

Timing and handshake:
- done falls on the next ce=1 edge. Q/R/ovf/dbz hold until the next FIX.
- Latency: done visible after 2W+1 ce-enabled edges following the accepting edge (33 for W=16); 1 edge for B==0.
- start while busy=1 is ignored; it is not queued.
- start in the same cycle done=1 is accepted; busy is back to 0 in that cycle.
- Inputs A/B are sampled only at the accepting edge; later changes have no effect.

Test Plan:
- W=16, A=1000, B=7, start one cycle → done exactly 33 edges later, Q=142, R=6, ovf=0, dbz=0, busy high for 33 cycles.
- A=-1000, B=7 → Q=-142 (0xFF72), R=-6 (0xFFFA); A=1000, B=-7 → Q=-142, R=6; A=-1000, B=-7 → Q=142, R=-6.
- A=0x4000_0000, B=2 → ovf=1, Q=0x7FFF, R=0; A=0x8000_0000, B=-1 → ovf=1, Q=0x7FFF, R=0; A=0xFFFF_8000, B=1 → ovf=0, Q=0x8000, R=0.
- B=0, A=-5 → done after 1 edge, dbz=1, ovf=0, Q=0x8000, R=0xFFFB; then A=5, B=0 → Q=0x7FFF, R=5.
- ce=0 for 10 cycles mid-CALC → done arrives exactly 10 cycles later with the correct result; start pulses with changed A/B during busy → ignored, result unchanged.
- arst_n low at CALC step 5 → immediately busy=0, done=0, Q=R=0, ovf=dbz=0; after release, new start A=100, B=10 → Q=10, R=0 after 33 edges.
